hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational hazard/forwarding logic.
- Resolves RAW hazards for two decode-stage source registers across NUM_SRC prioritised forwarding sources.
- Detects load-use stalls and tracks one multi-cycle execution unit (mul/div) with a latency-counting scoreboard that stalls dependent and structurally conflicting instructions.
- Sits between decode and execute; its outputs drive the decode operand muxes and the pipeline stall/flush controls.

Parameters:
- XLEN, 64, datapath width of forwarded data.
- REG_AW, 5, register address width.
- NUM_SRC, 5, number of forwarding sources; index 0 has the highest priority (youngest stage).
- CNT_W, 6, width of the multi-cycle latency counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- rs1  in  REG_AW  decode source register A.
- rs2  in  REG_AW  decode source register B.
- id_valid  in  1  decode holds a valid instruction.
- id_is_mc  in  1  decode instruction needs the multi-cycle unit.
- ex_regwrite  in  1  execute-stage instruction writes a register.
- ex_memread  in  1  execute-stage instruction is a load.
- ex_dst  in  REG_AW  execute-stage destination register.
- fwd_valid  in  NUM_SRC  per-source forwarding valid.
- fwd_dst  in  NUM_SRC*REG_AW  per-source destination; source i occupies slice i.
- fwd_data  in  NUM_SRC*XLEN  per-source result data.
- mc_start  in  1  multi-cycle op issued this cycle.
- mc_dst  in  REG_AW  destination of the issued multi-cycle op.
- mc_latency  in  CNT_W  cycles until the multi-cycle result is forwardable.
- mc_flush  in  1  kill the in-flight multi-cycle op (redirect).
- stall  out  1  hold PC, fetch and decode.
- clear  out  1  insert a bubble into execute.
- srca_mux  out  1  use srca_forward for operand A.
- srca_forward  out  XLEN  forwarded operand A.
- srcb_mux  out  1  use srcb_forward for operand B.
- srcb_forward  out  XLEN  forwarded operand B.
- mc_busy  out  1  multi-cycle unit occupied.
- mc_overrun  out  1  sticky: mc_start was received while busy.

Behaviour:
- Forwarding:
  - Purely combinational.
  - For operand A, select the lowest index i with fwd_valid[i] and fwd_dst slice i == rs1; drive srca_mux=1 and srca_forward=fwd_data slice i.
  - With no match, srca_mux=0 and srca_forward=0 (no latches).
  - Operand B uses rs2 identically.
  - Register 0 never matches: rs==0 gives mux=0.
- Load-use:
  - load_use = id_valid & ex_regwrite & ex_memread & ex_dst!=0 & (ex_dst==rs1 | ex_dst==rs2).
- Scoreboard state: cnt (CNT_W), pend_dst (REG_AW), overrun flag.
- mc_busy = (cnt != 0).
- Per clock edge, evaluated in priority order:
  - !reset: cnt=0, pend_dst=0, overrun=0.
  - mc_flush: cnt=0. A mc_start in the same cycle is discarded and overrun is not set.
  - mc_start & !mc_busy & mc_latency!=0: cnt=mc_latency, pend_dst=mc_dst.
  - mc_start & mc_busy: start is dropped; overrun=1 (sticky until reset).
  - Otherwise, if busy: cnt=cnt-1.
  - mc_latency==0: start accepted with no busy period and no overrun.
- Timing: a start accepted at edge t makes mc_busy high for exactly mc_latency cycles after t. On the edge where cnt reaches 0 the result must already be on a forwarding source.
- mc_raw = id_valid & mc_busy & pend_dst!=0 & (pend_dst==rs1 | pend_dst==rs2).
- mc_struct = id_valid & id_is_mc & mc_busy & !(cnt==1).
  - In the final busy cycle a new start is allowed, because the unit frees on that edge.
- stall = load_use | mc_raw | mc_struct.
- clear = stall; execute receives a bubble while decode holds.
- Forwarding outputs are valid regardless of stall. Decode ignores them while stalled.
- Every output is 0 in the cycle after reset with quiet inputs.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds outputs stall_cnt (32) and mc_stall_cnt (32).
  - stall_cnt increments every cycle stall==1.
  - mc_stall_cnt increments when (mc_raw | mc_struct) == 1.
  - Both saturate at all-ones and reset to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- NUM_SRC=5; source0 and source2 both valid with dst=3 (data 0xA, 0xB); rs1=3 -> srca_mux=1, srca_forward=0xA. With rs1=0 and a source dst=0 -> srca_mux=0.
- ex_memread=1, ex_regwrite=1, ex_dst=7, rs2=7, id_valid=1 -> stall=1, clear=1 in the same cycle. With ex_dst=0 -> stall=0.
- mc_start, mc_dst=9, latency=4 at edge t -> mc_busy high t+1..t+4. rs1=9 stalls for exactly those 4 cycles; a non-dependent rs1 does not stall.
- Busy with cnt=1, id_is_mc=1 -> stall=0. The same request with cnt=3 -> stall=1. mc_start with cnt=3 -> dropped, mc_overrun=1 and held.
- mc_start and mc_flush in the same cycle -> mc_busy stays 0 and mc_overrun stays 0. mc_flush mid-operation -> mc_busy=0 on the next cycle.
- reset low for one edge during cnt=5 -> cnt, mc_busy and mc_overrun are 0 after the edge; with HAZARD_PERF_EN, the counters also return to 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW forwarding select for two decode operands across
// NUM_SRC prioritised sources, load-use detection, and a latency-counting
// scoreboard for one multi-cycle (mul/div) unit.
// Optional build macro HAZARD_PERF_EN adds saturating stall_cnt and
// mc_stall_cnt performance counters.
//
// Handshake: mc_start is a single-cycle issue pulse with no ready. It is
// accepted only when the unit is idle (mc_busy==0) and mc_flush is low.
// A start that arrives while busy is dropped and latches mc_overrun. The
// in-flight op keeps counting down in that case, so its latency is unchanged.
module hazard_scoreboard #(
  parameter int XLEN    = 64,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 5,
  parameter int CNT_W   = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_AW-1:0]         rs1,
  input  logic [REG_AW-1:0]         rs2,
  input  logic                      id_valid,
  input  logic                      id_is_mc,
  input  logic                      ex_regwrite,
  input  logic                      ex_memread,
  input  logic [REG_AW-1:0]         ex_dst,
  input  logic [NUM_SRC-1:0]        fwd_valid,
  input  logic [NUM_SRC*REG_AW-1:0] fwd_dst,
  input  logic [NUM_SRC*XLEN-1:0]   fwd_data,
  input  logic                      mc_start,
  input  logic [REG_AW-1:0]         mc_dst,
  input  logic [CNT_W-1:0]          mc_latency,
  input  logic                      mc_flush,
  output logic                      stall,
  output logic                      clear,
  output logic                      srca_mux,
  output logic [XLEN-1:0]           srca_forward,
  output logic                      srcb_mux,
  output logic [XLEN-1:0]           srcb_forward,
  output logic                      mc_busy,
  output logic                      mc_overrun
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               mc_stall_cnt
`endif
);

  logic [CNT_W-1:0]  cnt;
  logic [REG_AW-1:0] pend_dst;
  logic              overrun;
  logic              load_use;
  logic              mc_raw;
  logic              mc_struct;

  // Operand A forwarding: scan from the oldest source down so the lowest
  // matching index (youngest stage) is the one left standing.
  always_comb begin
    srca_mux     = 1'b0;
    srca_forward = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_dst[i*REG_AW +: REG_AW] == rs1) && (rs1 != '0)) begin
        srca_mux     = 1'b1;
        srca_forward = fwd_data[i*XLEN +: XLEN];
      end
    end
  end

  // Operand B forwarding, same priority rule against rs2.
  always_comb begin
    srcb_mux     = 1'b0;
    srcb_forward = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_dst[i*REG_AW +: REG_AW] == rs2) && (rs2 != '0)) begin
        srcb_mux     = 1'b1;
        srcb_forward = fwd_data[i*XLEN +: XLEN];
      end
    end
  end

  // Stall sources: load result not yet available, pending multi-cycle
  // destination read, or a second mc op before the unit frees. In the final
  // busy cycle (cnt==1) the unit frees on the edge, so no structural stall.
  always_comb begin
    load_use  = id_valid & ex_regwrite & ex_memread & (ex_dst != '0) &
                ((ex_dst == rs1) | (ex_dst == rs2));
    mc_raw    = id_valid & mc_busy & (pend_dst != '0) &
                ((pend_dst == rs1) | (pend_dst == rs2));
    mc_struct = id_valid & id_is_mc & mc_busy & (cnt != CNT_W'(1));
    stall     = load_use | mc_raw | mc_struct;
    clear     = stall;
  end

  assign mc_busy    = (cnt != '0);
  assign mc_overrun = overrun;

  // Scoreboard: flush beats start; a zero-latency start is accepted but
  // leaves the unit idle; a start while busy is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      pend_dst <= '0;
      overrun  <= 1'b0;
    end else if (mc_flush) begin
      cnt <= '0;
    end else if (mc_start && !mc_busy) begin
      if (mc_latency != '0) begin
        cnt      <= mc_latency;
        pend_dst <= mc_dst;
      end
    end else if (mc_start && mc_busy) begin
      overrun <= 1'b1;
      cnt     <= cnt - 1'b1;
    end else if (mc_busy) begin
      cnt <= cnt - 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating stall counters for performance monitoring.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt    <= '0;
      mc_stall_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if ((mc_raw | mc_struct) && (mc_stall_cnt != '1))
        mc_stall_cnt <= mc_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed scenarios plus randomized traffic
// checked against a reference model that tracks the multi-cycle op as an
// absolute "result ready" cycle number.
module tb_hazard_scoreboard;
  localparam int XLEN    = 64;
  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 5;
  localparam int CNT_W   = 6;

  logic                      clk;
  logic                      reset;
  logic [REG_AW-1:0]         rs1, rs2;
  logic                      id_valid, id_is_mc;
  logic                      ex_regwrite, ex_memread;
  logic [REG_AW-1:0]         ex_dst;
  logic [NUM_SRC-1:0]        fwd_valid;
  logic [NUM_SRC*REG_AW-1:0] fwd_dst;
  logic [NUM_SRC*XLEN-1:0]   fwd_data;
  logic                      mc_start;
  logic [REG_AW-1:0]         mc_dst;
  logic [CNT_W-1:0]          mc_latency;
  logic                      mc_flush;
  logic                      stall, clear;
  logic                      srca_mux, srcb_mux;
  logic [XLEN-1:0]           srca_forward, srcb_forward;
  logic                      mc_busy, mc_overrun;
`ifdef HAZARD_PERF_EN
  logic [31:0]               stall_cnt, mc_stall_cnt;
  longint                    m_stall_cnt, m_mc_stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: cycle number, cycle at which the pending result
  // is ready (unit busy while cyc < ready_cyc), pending dst, sticky overrun.
  int                cyc = 0;
  int                ready_cyc = 0;
  logic [REG_AW-1:0] m_pend = '0;
  logic              m_ovr = 1'b0;

  hazard_scoreboard #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .id_valid(id_valid), .id_is_mc(id_is_mc),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_dst(ex_dst),
    .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
    .mc_start(mc_start), .mc_dst(mc_dst), .mc_latency(mc_latency), .mc_flush(mc_flush),
    .stall(stall), .clear(clear), .srca_mux(srca_mux), .srca_forward(srca_forward),
    .srcb_mux(srcb_mux), .srcb_forward(srcb_forward), .mc_busy(mc_busy), .mc_overrun(mc_overrun)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .mc_stall_cnt(mc_stall_cnt)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic m_busy();
    return ready_cyc > cyc;
  endfunction

  function automatic logic m_last();
    return ready_cyc == cyc + 1;
  endfunction

  function automatic logic e_load_use();
    return id_valid && ex_regwrite && ex_memread && ex_dst != 0 && (ex_dst == rs1 || ex_dst == rs2);
  endfunction

  function automatic logic e_mc_dep();
    logic raw, strct;
    raw   = id_valid && m_busy() && m_pend != 0 && (m_pend == rs1 || m_pend == rs2);
    strct = id_valid && id_is_mc && m_busy() && !m_last();
    return raw || strct;
  endfunction

  function automatic logic e_stall();
    return e_load_use() || e_mc_dep();
  endfunction

  // {hit, data}: first source in priority order whose dst equals rs.
  function automatic logic [XLEN:0] e_fwd(input logic [REG_AW-1:0] rs);
    if (rs == 0) return '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (fwd_valid[i] && fwd_dst[i*REG_AW +: REG_AW] == rs)
        return {1'b1, fwd_data[i*XLEN +: XLEN]};
    return '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic quiet();
    rs1 = 0; rs2 = 0; id_valid = 0; id_is_mc = 0;
    ex_regwrite = 0; ex_memread = 0; ex_dst = 0;
    fwd_valid = 0; fwd_dst = 0; fwd_data = 0;
    mc_start = 0; mc_dst = 0; mc_latency = 0; mc_flush = 0;
  endtask

  // One clock edge; the model follows the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
`ifdef HAZARD_PERF_EN
    if (!reset) begin
      m_stall_cnt = 0; m_mc_stall_cnt = 0;
    end else begin
      if (e_stall() && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (e_mc_dep() && m_mc_stall_cnt < 64'hFFFF_FFFF) m_mc_stall_cnt++;
    end
`endif
    if (!reset) begin
      ready_cyc = 0; m_pend = 0; m_ovr = 0;
    end else if (mc_flush) begin
      ready_cyc = 0;
    end else if (mc_start && !m_busy()) begin
      if (mc_latency != 0) begin
        ready_cyc = cyc + 1 + int'(mc_latency);
        m_pend = mc_dst;
      end
    end else if (mc_start) begin
      m_ovr = 1'b1;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic start_mc(input logic [REG_AW-1:0] dst, input logic [CNT_W-1:0] lat);
    mc_start = 1; mc_dst = dst; mc_latency = lat;
    tick();
    mc_start = 0; mc_dst = 0; mc_latency = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #2;
    n_vec++;
    if ({stall, clear, srca_mux, srcb_mux, mc_busy, mc_overrun} !== 6'b0 ||
        srca_forward !== '0 || srcb_forward !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got stall=%b clear=%b amux=%b bmux=%b busy=%b ovr=%b expected all 0",
               stall, clear, srca_mux, srcb_mux, mc_busy, mc_overrun);
    end
`ifdef HAZARD_PERF_EN
    n_vec++;
    if (stall_cnt !== 0 || mc_stall_cnt !== 0) begin
      n_err++;
      $display("FAIL reset_perf: got %0d/%0d expected 0/0", stall_cnt, mc_stall_cnt);
    end
`endif
  endtask

  task automatic test_forwarding();
    quiet();
    fwd_valid = 5'b00101;
    fwd_dst[0*REG_AW +: REG_AW] = 3;  fwd_data[0*XLEN +: XLEN] = 64'hA;
    fwd_dst[2*REG_AW +: REG_AW] = 3;  fwd_data[2*XLEN +: XLEN] = 64'hB;
    rs1 = 3; rs2 = 3;
    #2;
    n_vec++;
    if (srca_mux !== 1'b1 || srca_forward !== 64'hA) begin
      n_err++;
      $display("FAIL fwd_a_priority: got mux=%b data=%h expected 1/a", srca_mux, srca_forward);
    end
    n_vec++;
    if (srcb_mux !== 1'b1 || srcb_forward !== 64'hA) begin
      n_err++;
      $display("FAIL fwd_b_priority: got mux=%b data=%h expected 1/a", srcb_mux, srcb_forward);
    end
    fwd_valid = 5'b00100;
    #2;
    n_vec++;
    if (srca_mux !== 1'b1 || srca_forward !== 64'hB) begin
      n_err++;
      $display("FAIL fwd_a_src2: got mux=%b data=%h expected 1/b", srca_mux, srca_forward);
    end
    fwd_valid = 5'b00010;
    fwd_dst[1*REG_AW +: REG_AW] = 0; fwd_data[1*XLEN +: XLEN] = 64'hDEAD;
    rs1 = 0; rs2 = 9;
    #2;
    n_vec++;
    if (srca_mux !== 1'b0 || srca_forward !== '0 || srcb_mux !== 1'b0 || srcb_forward !== '0) begin
      n_err++;
      $display("FAIL fwd_reg0: got amux=%b adata=%h bmux=%b bdata=%h expected 0/0/0/0",
               srca_mux, srca_forward, srcb_mux, srcb_forward);
    end
    tick();
  endtask

  task automatic test_load_use();
    quiet();
    ex_memread = 1; ex_regwrite = 1; ex_dst = 7; rs2 = 7; rs1 = 4; id_valid = 1;
    #2;
    n_vec++;
    if (stall !== 1'b1 || clear !== 1'b1) begin
      n_err++;
      $display("FAIL load_use_hit: got stall=%b clear=%b expected 1/1", stall, clear);
    end
    ex_dst = 0; rs2 = 0;
    #2;
    n_vec++;
    if (stall !== 1'b0 || clear !== 1'b0) begin
      n_err++;
      $display("FAIL load_use_r0: got stall=%b clear=%b expected 0/0", stall, clear);
    end
    ex_dst = 7; rs2 = 7; ex_memread = 0;
    #2;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL load_use_not_load: got stall=%b expected 0", stall);
    end
    tick();
    quiet();
  endtask

  task automatic test_mc_latency();
    for (int run = 0; run < 2; run++) begin
      quiet();
      start_mc(9, 4);
      id_valid = 1;
      rs1 = (run == 0) ? 5'd9 : 5'd10;
      for (int k = 1; k <= 6; k++) begin
        #2;
        n_vec++;
        if (mc_busy !== (k <= 4)) begin
          n_err++;
          $display("FAIL mc_busy_window: cycle %0d got %b expected %b", k, mc_busy, (k <= 4));
        end
        n_vec++;
        if (stall !== (run == 0 && k <= 4)) begin
          n_err++;
          $display("FAIL mc_raw_stall: run %0d cycle %0d got %b expected %b", run, k, stall, (run == 0 && k <= 4));
        end
        tick();
      end
    end
    quiet();
  endtask

  task automatic test_flush();
    do_reset();
    mc_flush = 1;
    start_mc(9, 5);
    mc_flush = 0;
    #2;
    n_vec++;
    if (mc_busy !== 1'b0 || mc_overrun !== 1'b0) begin
      n_err++;
      $display("FAIL flush_with_start: got busy=%b ovr=%b expected 0/0", mc_busy, mc_overrun);
    end
    start_mc(11, 6);
    tick();
    mc_flush = 1;
    tick();
    mc_flush = 0;
    #2;
    n_vec++;
    if (mc_busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_mid_op: got busy=%b expected 0", mc_busy);
    end
    tick();
  endtask

  task automatic test_struct_overrun();
    quiet();
    start_mc(12, 4);
    id_valid = 1; id_is_mc = 1; rs1 = 1; rs2 = 2;
    tick();                  // cnt now 3
    #2;
    n_vec++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL mc_struct_cnt3: got stall=%b expected 1", stall);
    end
    mc_start = 1; mc_dst = 20; mc_latency = 9;
    tick();                  // dropped start, cnt now 2
    mc_start = 0;
    #2;
    n_vec++;
    if (mc_overrun !== 1'b1 || mc_busy !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_set: got ovr=%b busy=%b expected 1/1", mc_overrun, mc_busy);
    end
    tick();                  // cnt now 1
    #2;
    n_vec++;
    if (stall !== 1'b0 || mc_busy !== 1'b1) begin
      n_err++;
      $display("FAIL mc_struct_cnt1: got stall=%b busy=%b expected 0/1", stall, mc_busy);
    end
    tick();
    tick();
    #2;
    n_vec++;
    if (mc_overrun !== 1'b1 || mc_busy !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_sticky: got ovr=%b busy=%b expected 1/0", mc_overrun, mc_busy);
    end
    quiet();
  endtask

  task automatic test_reset_midop();
    quiet();
    start_mc(13, 8);
    id_valid = 1; rs1 = 13;
    tick(); tick(); tick();  // cnt now 5
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #2;
    n_vec++;
    if (mc_busy !== 1'b0 || mc_overrun !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_op: got busy=%b ovr=%b stall=%b expected 0/0/0", mc_busy, mc_overrun, stall);
    end
`ifdef HAZARD_PERF_EN
    n_vec++;
    if (stall_cnt !== 0 || mc_stall_cnt !== 0) begin
      n_err++;
      $display("FAIL reset_mid_op_perf: got %0d/%0d expected 0/0", stall_cnt, mc_stall_cnt);
    end
`endif
    quiet();
    tick();
  endtask

  task automatic test_random();
    logic [XLEN:0] ea, eb;
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 299) != 0);
      rs1         = REG_AW'($urandom_range(0, 7));
      rs2         = REG_AW'($urandom_range(0, 7));
      id_valid    = ($urandom_range(0, 3) != 0);
      id_is_mc    = ($urandom_range(0, 2) == 0);
      ex_regwrite = $urandom_range(0, 1);
      ex_memread  = $urandom_range(0, 1);
      ex_dst      = REG_AW'($urandom_range(0, 7));
      fwd_valid   = NUM_SRC'($urandom);
      for (int i = 0; i < NUM_SRC; i++) begin
        fwd_dst[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
        fwd_data[i*XLEN +: XLEN]    = {$urandom, $urandom};
      end
      mc_start   = ($urandom_range(0, 3) == 0);
      mc_dst     = REG_AW'($urandom_range(0, 7));
      mc_latency = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(0, 63)) : CNT_W'($urandom_range(0, 6));
      mc_flush   = ($urandom_range(0, 31) == 0);
      #2;
      ea = e_fwd(rs1);
      eb = e_fwd(rs2);
      n_vec++;
      if (stall !== e_stall() || clear !== e_stall()) begin
        n_err++;
        $display("FAIL rnd_stall: cyc %0d got stall=%b clear=%b expected %b", cyc, stall, clear, e_stall());
      end
      n_vec++;
      if ({srca_mux, srca_forward} !== ea || {srcb_mux, srcb_forward} !== eb) begin
        n_err++;
        $display("FAIL rnd_fwd: cyc %0d got a=%b/%h b=%b/%h expected a=%b/%h b=%b/%h", cyc,
                 srca_mux, srca_forward, srcb_mux, srcb_forward, ea[XLEN], ea[XLEN-1:0], eb[XLEN], eb[XLEN-1:0]);
      end
      n_vec++;
      if (mc_busy !== m_busy() || mc_overrun !== m_ovr) begin
        n_err++;
        $display("FAIL rnd_mc: cyc %0d got busy=%b ovr=%b expected %b/%b", cyc, mc_busy, mc_overrun, m_busy(), m_ovr);
      end
`ifdef HAZARD_PERF_EN
      n_vec++;
      if (stall_cnt !== 32'(m_stall_cnt) || mc_stall_cnt !== 32'(m_mc_stall_cnt)) begin
        n_err++;
        $display("FAIL rnd_perf: cyc %0d got %0d/%0d expected %0d/%0d", cyc, stall_cnt, mc_stall_cnt,
                 m_stall_cnt, m_mc_stall_cnt);
      end
`endif
      tick();
    end
    reset = 1'b1;
    quiet();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
`ifdef HAZARD_PERF_EN
    m_stall_cnt = 0; m_mc_stall_cnt = 0;
`endif
    quiet();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mc_latency();
    test_flush();
    test_struct_overrun();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
